// File: rtl/guvm_cache_stub.sv
// guvm_cache_stub: cache-side responder for the GUVM core benches.
// Answers fetch/load requests from FIFOs with wait states and logs stores.

module guvm_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   full_nxt_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  wptr_d;
  logic [AW:0]  rptr_q;
  logic [AW:0]  rptr_d;

  assign wptr_d  = wptr_q + {{AW{1'b0}}, push_i};
  assign rptr_d  = rptr_q + {{AW{1'b0}}, pop_i};
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign level_o = wptr_q - rptr_q;
  assign empty_o = wptr_q == rptr_q;

  // The extra pointer bit separates full from empty.
  assign full_o =
    (wptr_q[AW] != rptr_q[AW]) &&
    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign full_nxt_o =
    (wptr_d[AW] != rptr_d[AW]) &&
    (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end
endmodule

module guvm_chan #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [WAIT_W-1:0] wait_cfg_i,
  input  logic              stall_i,
  output logic              hold_o,
  output logic              idle_o,
  output logic              acc_o,
  output logic              fire_o
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_o   = 1'b0;
    fire_o  = 1'b0;
    hold_o  = 1'b1;
    idle_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idle_o = 1'b1;
        if (req_i) begin
          acc_o = 1'b1;
          if (wait_cfg_i != '0) begin
            state_d = S_WAIT;
            cnt_d   = wait_cfg_i;
          end else if (stall_i) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_W'(1);
          end else begin
            state_d = S_RESP;
            fire_o  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        hold_o = 1'b0;
        // Parked at cnt==1 while the store log is full.
        if (cnt_q != WAIT_W'(1)) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else if (!stall_i) begin
          state_d = S_RESP;
          fire_o  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule

module guvm_cache_stub #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int INST_DEPTH  = 8,
  parameter int LOAD_DEPTH  = 4,
  parameter int STORE_DEPTH = 4,
  parameter int WAIT_W      = 4,
  parameter logic [DATA_W-1:0] NOP_INST =
    DATA_W'(32'h0100_0000)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WAIT_W-1:0]       wait_cfg,
  input  logic                    inst_in_valid,
  output logic                    inst_in_ready,
  input  logic [DATA_W-1:0]       inst_in_data,
  input  logic                    load_in_valid,
  output logic                    load_in_ready,
  input  logic [DATA_W-1:0]       load_in_data,
  input  logic                    ic_req,
  input  logic [ADDR_W-1:0]       ic_addr,
  output logic                    ic_hold,
  output logic [DATA_W-1:0]       ic_data,
  input  logic                    dc_req,
  input  logic                    dc_write,
  input  logic [ADDR_W-1:0]       dc_addr,
  input  logic [DATA_W-1:0]       dc_wdata,
  output logic                    dc_hold,
  output logic [DATA_W-1:0]       dc_data,
  output logic                    st_valid,
  input  logic                    st_ready,
  output logic [ADDR_W-1:0]       st_addr,
  output logic [DATA_W-1:0]       st_data,
  output logic [$clog2(INST_DEPTH):0] inst_level,
  output logic [7:0]              ic_underflow,
  output logic [7:0]              dc_underflow
);
  localparam int SW = ADDR_W + DATA_W;

  logic ic_addr_unused;
  assign ic_addr_unused = ^ic_addr;

  logic inst_rdy_q;
  logic load_rdy_q;
  logic inst_push;
  logic inst_pop;
  logic inst_empty;
  logic inst_full_n;
  logic inst_full_unused;
  logic [DATA_W-1:0] inst_head;

  logic load_push;
  logic load_pop;
  logic load_empty;
  logic load_full_n;
  logic load_full_unused;
  logic [DATA_W-1:0] load_head;
  logic [$clog2(LOAD_DEPTH):0] load_lvl_unused;

  logic st_push;
  logic st_pop;
  logic st_empty;
  logic st_full;
  logic st_full_n_unused;
  logic [SW-1:0] st_head;
  logic [$clog2(STORE_DEPTH):0] st_lvl_unused;

  logic ic_fire;
  logic ic_acc_unused;
  logic ic_idle_unused;
  logic dc_fire;
  logic dc_acc;
  logic dc_idle;
  logic dc_stall;

  logic              dc_wr_q;
  logic [ADDR_W-1:0] dc_addr_q;
  logic [DATA_W-1:0] dc_wdata_q;
  logic              dc_wr_e;
  logic [ADDR_W-1:0] dc_addr_e;
  logic [DATA_W-1:0] dc_wdata_e;

  logic [DATA_W-1:0] ic_data_q;
  logic [DATA_W-1:0] ic_data_d;
  logic [DATA_W-1:0] dc_data_q;
  logic [DATA_W-1:0] dc_data_d;
  logic [7:0]        ic_unf_q;
  logic [7:0]        ic_unf_d;
  logic [7:0]        dc_unf_q;
  logic [7:0]        dc_unf_d;

  assign inst_in_ready = inst_rdy_q;
  assign load_in_ready = load_rdy_q;
  assign inst_push = inst_in_valid & inst_rdy_q;
  assign load_push = load_in_valid & load_rdy_q;
  assign inst_pop  = ic_fire & ~inst_empty;

  // In IDLE the request fields are live; later they are latched.
  assign dc_wr_e    = dc_idle ? dc_write : dc_wr_q;
  assign dc_addr_e  = dc_idle ? dc_addr  : dc_addr_q;
  assign dc_wdata_e = dc_idle ? dc_wdata : dc_wdata_q;

  assign load_pop = dc_fire & ~dc_wr_e & ~load_empty;
  assign st_push  = dc_fire & dc_wr_e;
  assign st_valid = ~st_empty;
  assign st_pop   = st_valid & st_ready;
  assign dc_stall = dc_wr_e & st_full & ~st_pop;
  assign st_addr  = st_head[SW-1:DATA_W];
  assign st_data  = st_head[DATA_W-1:0];

  assign ic_data      = ic_data_q;
  assign dc_data      = dc_data_q;
  assign ic_underflow = ic_unf_q;
  assign dc_underflow = dc_unf_q;

  guvm_fifo #(.W(DATA_W), .DEPTH(INST_DEPTH)) u_inst (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inst_push),
    .pop_i      (inst_pop),
    .data_i     (inst_in_data),
    .head_o     (inst_head),
    .empty_o    (inst_empty),
    .full_o     (inst_full_unused),
    .full_nxt_o (inst_full_n),
    .level_o    (inst_level)
  );

  guvm_fifo #(.W(DATA_W), .DEPTH(LOAD_DEPTH)) u_load (
    .clk        (clk),
    .rst        (rst),
    .push_i     (load_push),
    .pop_i      (load_pop),
    .data_i     (load_in_data),
    .head_o     (load_head),
    .empty_o    (load_empty),
    .full_o     (load_full_unused),
    .full_nxt_o (load_full_n),
    .level_o    (load_lvl_unused)
  );

  guvm_fifo #(.W(SW), .DEPTH(STORE_DEPTH)) u_st (
    .clk        (clk),
    .rst        (rst),
    .push_i     (st_push),
    .pop_i      (st_pop),
    .data_i     ({dc_addr_e, dc_wdata_e}),
    .head_o     (st_head),
    .empty_o    (st_empty),
    .full_o     (st_full),
    .full_nxt_o (st_full_n_unused),
    .level_o    (st_lvl_unused)
  );

  guvm_chan #(.WAIT_W(WAIT_W)) u_ic (
    .clk        (clk),
    .rst        (rst),
    .req_i      (ic_req),
    .wait_cfg_i (wait_cfg),
    .stall_i    (1'b0),
    .hold_o     (ic_hold),
    .idle_o     (ic_idle_unused),
    .acc_o      (ic_acc_unused),
    .fire_o     (ic_fire)
  );

  guvm_chan #(.WAIT_W(WAIT_W)) u_dc (
    .clk        (clk),
    .rst        (rst),
    .req_i      (dc_req),
    .wait_cfg_i (wait_cfg),
    .stall_i    (dc_stall),
    .hold_o     (dc_hold),
    .idle_o     (dc_idle),
    .acc_o      (dc_acc),
    .fire_o     (dc_fire)
  );

  always_comb begin
    ic_data_d = ic_data_q;
    ic_unf_d  = ic_unf_q;
    dc_data_d = dc_data_q;
    dc_unf_d  = dc_unf_q;
    if (ic_fire) begin
      if (inst_empty) begin
        ic_data_d = NOP_INST;
        if (ic_unf_q != 8'hFF) begin
          ic_unf_d = ic_unf_q + 8'd1;
        end
      end else begin
        ic_data_d = inst_head;
      end
    end
    if (dc_fire) begin
      dc_data_d = '0;
      if (!dc_wr_e) begin
        if (load_empty) begin
          if (dc_unf_q != 8'hFF) begin
            dc_unf_d = dc_unf_q + 8'd1;
          end
        end else begin
          dc_data_d = load_head;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rdy_q <= 1'b0;
      load_rdy_q <= 1'b0;
      ic_data_q  <= NOP_INST;
      dc_data_q  <= '0;
      ic_unf_q   <= '0;
      dc_unf_q   <= '0;
      dc_wr_q    <= 1'b0;
      dc_addr_q  <= '0;
      dc_wdata_q <= '0;
    end else begin
      inst_rdy_q <= ~inst_full_n;
      load_rdy_q <= ~load_full_n;
      ic_data_q  <= ic_data_d;
      dc_data_q  <= dc_data_d;
      ic_unf_q   <= ic_unf_d;
      dc_unf_q   <= dc_unf_d;
      if (dc_acc) begin
        dc_wr_q    <= dc_write;
        dc_addr_q  <= dc_addr;
        dc_wdata_q <= dc_wdata;
      end
    end
  end
endmodule

// File: tb/tb_guvm_cache_stub.sv
// Directed bench for guvm_cache_stub.
// Expected words come from scoreboard queues filled at push time.

module tb_guvm_cache_stub;
  localparam logic [31:0] NOP = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wait_cfg = '0;
  logic        inst_in_valid = 1'b0;
  logic        inst_in_ready;
  logic [31:0] inst_in_data = '0;
  logic        load_in_valid = 1'b0;
  logic        load_in_ready;
  logic [31:0] load_in_data = '0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_hold;
  logic [31:0] ic_data;
  logic        dc_req = 1'b0;
  logic        dc_write = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic        dc_hold;
  logic [31:0] dc_data;
  logic        st_valid;
  logic        st_ready = 1'b0;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  inst_level;
  logic [7:0]  ic_underflow;
  logic [7:0]  dc_underflow;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] ic_sb [$];
  logic [31:0] ld_sb [$];
  logic [63:0] st_sb [$];

  always #5 clk = ~clk;

  guvm_cache_stub dut (
    .clk           (clk),
    .rst           (rst),
    .wait_cfg      (wait_cfg),
    .inst_in_valid (inst_in_valid),
    .inst_in_ready (inst_in_ready),
    .inst_in_data  (inst_in_data),
    .load_in_valid (load_in_valid),
    .load_in_ready (load_in_ready),
    .load_in_data  (load_in_data),
    .ic_req        (ic_req),
    .ic_addr       (ic_addr),
    .ic_hold       (ic_hold),
    .ic_data       (ic_data),
    .dc_req        (dc_req),
    .dc_write      (dc_write),
    .dc_addr       (dc_addr),
    .dc_wdata      (dc_wdata),
    .dc_hold       (dc_hold),
    .dc_data       (dc_data),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .inst_level    (inst_level),
    .ic_underflow  (ic_underflow),
    .dc_underflow  (dc_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ic_exp();
    if (ic_sb.size() == 0) return NOP;
    return ic_sb.pop_front();
  endfunction

  function automatic logic [31:0] ld_exp();
    if (ld_sb.size() == 0) return 32'h0;
    return ld_sb.pop_front();
  endfunction

  task automatic push_inst(input logic [31:0] w);
    inst_in_valid = 1'b1;
    inst_in_data  = w;
    ic_sb.push_back(w);
    tick();
    inst_in_valid = 1'b0;
  endtask

  task automatic fetch0(input string tag);
    wait_cfg = 4'd0;
    ic_req   = 1'b1;
    tick();
    ic_req = 1'b0;
    chk({tag, "_hold"}, 64'(ic_hold), 64'd1);
    chk({tag, "_data"}, 64'(ic_data), 64'(ic_exp()));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    chk("rst_ic_hold", 64'(ic_hold), 64'd1);
    chk("rst_dc_hold", 64'(dc_hold), 64'd1);
    chk("rst_ic_data", 64'(ic_data), 64'(NOP));
    chk("rst_dc_data", 64'(dc_data), 64'd0);
    chk("rst_iready", 64'(inst_in_ready), 64'd0);
    chk("rst_lready", 64'(load_in_ready), 64'd0);
    chk("rst_st_valid", 64'(st_valid), 64'd0);
    chk("rst_level", 64'(inst_level), 64'd0);
    chk("rst_icunf", 64'(ic_underflow), 64'd0);
    chk("rst_dcunf", 64'(dc_underflow), 64'd0);
    rst = 1'b0;
    tick();
    chk("ready_rise", 64'(inst_in_ready), 64'd1);

    // Three words, req held high, zero wait states
    push_inst(32'hA000_0001);
    push_inst(32'hA000_0002);
    push_inst(32'hA000_0003);
    chk("level3", 64'(inst_level), 64'd3);
    wait_cfg = 4'd0;
    ic_req   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_hold", 64'(ic_hold), 64'd1);
      chk("t1_data", 64'(ic_data), 64'(ic_exp()));
      chk("t1_level", 64'(inst_level), 64'(ic_sb.size()));
      if (i == 3) ic_req = 1'b0;
      tick();
      chk("t1_data_held", 64'(ic_data), 64'(i < 3 ? 32'hA000_0001 + i : NOP));
    end
    chk("t1_icunf", 64'(ic_underflow), 64'd1);

    // Three wait states
    push_inst(32'hB000_0004);
    wait_cfg = 4'd3;
    ic_req   = 1'b1;
    tick();
    ic_req = 1'b0;
    n = 0;
    while (ic_hold == 1'b0 && n < 10) begin
      n++;
      tick();
    end
    chk("w3_low_cycles", 64'(n), 64'd3);
    chk("w3_data", 64'(ic_data), 64'(ic_exp()));
    tick();
    chk("w3_hold_after", 64'(ic_hold), 64'd1);
    chk("w3_data_kept", 64'(ic_data), 64'hB000_0004);

    // Loads: one queued word, then underflow
    load_in_valid = 1'b1;
    load_in_data  = 32'hDEAD_BEEF;
    ld_sb.push_back(32'hDEAD_BEEF);
    tick();
    load_in_valid = 1'b0;
    wait_cfg = 4'd0;
    dc_req   = 1'b1;
    dc_write = 1'b0;
    tick();
    dc_req = 1'b0;
    chk("ld1_data", 64'(dc_data), 64'(ld_exp()));
    tick();
    dc_req = 1'b1;
    tick();
    dc_req = 1'b0;
    chk("ld2_data", 64'(dc_data), 64'(ld_exp()));
    chk("ld2_dcunf", 64'(dc_underflow), 64'd1);
    tick();

    // Five stores into a four-deep log
    for (int i = 0; i < 5; i++) begin
      dc_req   = 1'b1;
      dc_write = 1'b1;
      dc_addr  = 32'h1000 + 32'(i * 4);
      dc_wdata = 32'hC0DE_0000 + 32'(i);
      st_sb.push_back({dc_addr, dc_wdata});
      tick();
      dc_req = 1'b0;
      if (i < 4) begin
        chk("st_resp_hold", 64'(dc_hold), 64'd1);
        chk("st_resp_data", 64'(dc_data), 64'd0);
        tick();
      end
    end
    chk("st5_stall", 64'(dc_hold), 64'd0);
    tick();
    chk("st5_still", 64'(dc_hold), 64'd0);
    st_ready = 1'b1;
    chk("st_valid", 64'(st_valid), 64'd1);
    chk("st_head0", {st_addr, st_data}, st_sb.pop_front());
    tick();
    st_ready = 1'b0;
    chk("st5_resp", 64'(dc_hold), 64'd1);
    chk("st5_data", 64'(dc_data), 64'd0);
    tick();
    st_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("st_drain_v", 64'(st_valid), 64'd1);
      chk("st_drain", {st_addr, st_data}, st_sb.pop_front());
      tick();
    end
    st_ready = 1'b0;
    chk("st_empty", 64'(st_valid), 64'd0);

    // Fill the instruction FIFO, ninth word waits
    inst_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inst_in_data = 32'hD000_0000 + 32'(i);
      ic_sb.push_back(inst_in_data);
      tick();
    end
    inst_in_data = 32'hD000_0008;
    ic_sb.push_back(inst_in_data);
    chk("full_ready", 64'(inst_in_ready), 64'd0);
    chk("full_level", 64'(inst_level), 64'd8);
    tick();
    chk("full_ready2", 64'(inst_in_ready), 64'd0);
    wait_cfg = 4'd0;
    ic_req   = 1'b1;
    tick();
    ic_req = 1'b0;
    chk("full_pop_data", 64'(ic_data), 64'(ic_exp()));
    chk("full_ready3", 64'(inst_in_ready), 64'd1);
    tick();
    inst_in_valid = 1'b0;
    chk("ninth_level", 64'(inst_level), 64'd8);
    for (int i = 0; i < 8; i++) fetch0("drain");
    chk("drain_level", 64'(inst_level), 64'd0);

    // Both channels respond in the same cycle
    inst_in_valid = 1'b1;
    inst_in_data  = 32'hE000_000E;
    ic_sb.push_back(inst_in_data);
    load_in_valid = 1'b1;
    load_in_data  = 32'hF000_000F;
    ld_sb.push_back(load_in_data);
    tick();
    inst_in_valid = 1'b0;
    load_in_valid = 1'b0;
    wait_cfg = 4'd2;
    ic_req   = 1'b1;
    dc_req   = 1'b1;
    dc_write = 1'b0;
    tick();
    ic_req = 1'b0;
    dc_req = 1'b0;
    chk("dual_wait", 64'({ic_hold, dc_hold}), 64'd0);
    tick();
    tick();
    chk("dual_hold", 64'({ic_hold, dc_hold}), 64'd3);
    chk("dual_ic", 64'(ic_data), 64'(ic_exp()));
    chk("dual_dc", 64'(dc_data), 64'(ld_exp()));
    tick();

    // Reset in WAIT with a queued instruction
    push_inst(32'h5555_AAAA);
    wait_cfg = 4'd5;
    ic_req   = 1'b1;
    tick();
    ic_req = 1'b0;
    tick();
    chk("abort_wait", 64'(ic_hold), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ic_sb.delete();
    chk("abort_hold", 64'(ic_hold), 64'd1);
    chk("abort_data", 64'(ic_data), 64'(NOP));
    chk("abort_level", 64'(inst_level), 64'd0);
    chk("abort_icunf", 64'(ic_underflow), 64'd0);
    tick();
    chk("abort_ready", 64'(inst_in_ready), 64'd1);
    chk("abort_data2", 64'(ic_data), 64'(NOP));
    chk("abort_level2", 64'(inst_level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
